// File: rtl/seq_adder_pkg.sv
// rtl/seq_adder_pkg.sv - shared constants, FSM state type and clog2 helper for seq_wide_adder
package seq_adder_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SLICE = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cla_slice.sv
// rtl/cla_slice.sv - SLICE-bit combinational carry-lookahead adder, 4-bit lookahead groups
module cla_slice #(
    parameter int SLICE = 16
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);

    localparam int GRP  = 4;
    localparam int NGRP = (SLICE + GRP - 1) / GRP;

    logic [SLICE-1:0] w_g;
    logic [SLICE-1:0] w_p;
    logic [SLICE-1:0] w_c;
    logic [NGRP:0]    w_grp_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Group carries come from each group's generate/propagate pair, then bit carries
    // are resolved inside each group from that group's carry-in.
    always_comb begin
        logic gg;
        logic gp;
        logic ci;
        w_grp_c    = '0;
        w_grp_c[0] = cin;
        for (int g = 0; g < NGRP; g++) begin
            gg = 1'b0;
            gp = 1'b1;
            for (int k = g * GRP; k < (g + 1) * GRP && k < SLICE; k++) begin
                gg = w_g[k] | (w_p[k] & gg);
                gp = gp & w_p[k];
            end
            w_grp_c[g+1] = gg | (gp & w_grp_c[g]);
        end
        w_c = '0;
        for (int i = 0; i < SLICE; i++) begin
            ci = w_grp_c[i / GRP];
            for (int k = (i / GRP) * GRP; k < i; k++) begin
                ci = w_g[k] | (w_p[k] & ci);
            end
            w_c[i] = ci;
        end
    end

    assign sum  = w_p ^ w_c;
    assign cout = w_grp_c[NGRP];

endmodule

// File: rtl/seq_wide_adder.sv
// rtl/seq_wide_adder.sv - multi-cycle WIDTH-bit adder, one SLICE-bit chunk per clock, LSB first
// Optional signed-overflow output enabled by defining SEQ_ADDER_OVF_EN.
module seq_wide_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef SEQ_ADDER_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    localparam int NSLICES = WIDTH / SLICE;
    localparam int IDX_W   = (clog2(NSLICES) < 1) ? 1 : clog2(NSLICES);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
`ifdef SEQ_ADDER_OVF_EN
    logic             r_ovf;
`endif

    logic [SLICE-1:0] w_slice_a;
    logic [SLICE-1:0] w_slice_b;
    logic [SLICE-1:0] w_slice_sum;
    logic             w_slice_cout;
    logic             w_last;

    assign w_slice_a = r_op_a[int'(r_idx)*SLICE +: SLICE];
    assign w_slice_b = r_op_b[int'(r_idx)*SLICE +: SLICE];
    assign w_last    = (r_idx == IDX_W'(NSLICES - 1));

    cla_slice #(
        .SLICE (SLICE)
    ) u_cla_slice (
        .a    (w_slice_a),
        .b    (w_slice_b),
        .cin  (r_carry),
        .sum  (w_slice_sum),
        .cout (w_slice_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
`ifdef SEQ_ADDER_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op_a  <= a;
                        r_op_b  <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum[int'(r_idx)*SLICE +: SLICE] <= w_slice_sum;
                    r_carry                           <= w_slice_cout;
                    if (w_last) begin
                        r_cout  <= w_slice_cout;
`ifdef SEQ_ADDER_OVF_EN
                        // On the last chunk the slice MSB is the final sum MSB.
                        r_ovf   <= (r_op_a[WIDTH-1] == r_op_b[WIDTH-1]) &&
                                   (w_slice_sum[SLICE-1] != r_op_a[WIDTH-1]);
`endif
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
`ifdef SEQ_ADDER_OVF_EN
    assign ovf       = r_ovf;
`endif

endmodule
